// File: rtl/conv_pkg.sv
// Shared constants, width helper and FSM encoding for the convolution front-end.
package conv_pkg;
  localparam int DATA_WIDTH_DEF = 16;
  localparam int MAX_W_DEF      = 128;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Width that holds 0..max_w inclusive.
  function automatic int aw_of(input int max_w);
    return $clog2(max_w) + 1;
  endfunction
endpackage

// File: rtl/sdp_bram.sv
// Simple dual-port block RAM: one write port, one registered read port with enable.
module sdp_bram #(
  parameter int DW     = 16,
  parameter int DEPTH  = 128,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DW-1:0]     wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DW-1:0]     rd_data
);
  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end
endmodule

// File: rtl/window_shift_reg_kxk.sv
// K x K window: each shift moves columns left and loads a masked new right column.
module window_shift_reg_kxk #(
  parameter int DW = 16,
  parameter int K  = 3
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         en,
  input  logic                         clr,
  input  logic [K-1:0]                 mask,
  input  logic [K-1:0][DW-1:0]         col,
  output logic [K-1:0][K-1:0][DW-1:0]  win_next
);
  logic [K-1:0][K-1:0][DW-1:0] win;

  // clr drops the old columns so a new row starts with left zero padding.
  always_comb begin
    win_next = win;
    for (int r = 0; r < K; r++) begin
      for (int c = 0; c < K - 1; c++) win_next[r][c] = clr ? '0 : win[r][c+1];
      win_next[r][K-1] = mask[r] ? col[r] : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset)   win <= '0;
    else if (en) win <= win_next;
  end
endmodule

// File: rtl/sliding_window_gen.sv
// Streams a raster image in and emits one zero-padded K x K window per pixel.
module sliding_window_gen
  import conv_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int K          = 3,
  parameter int MAX_W      = MAX_W_DEF,
  localparam int AW        = aw_of(MAX_W)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic [AW-1:0]                img_width,
  input  logic [AW-1:0]                img_height,
  input  logic [DATA_WIDTH-1:0]        s_data,
  input  logic                         s_valid,
  output logic                         s_ready,
  output logic [K*K*DATA_WIDTH-1:0]    m_window,
  output logic                         m_valid,
  input  logic                         m_ready,
  output logic                         busy,
  output logic                         done
);
  localparam int P  = (K - 1) / 2;
  localparam int CW = AW + 1;
  localparam int NW = 2 * AW;

  state_t state, state_n;
  logic [AW-1:0] w_q, h_q;
  logic [CW-1:0] row, col;
  logic [NW-1:0] win_cnt, total;
  logic grid_end, consume, emit, out_hold, stall, adv, accept;
  logic last_col, last_row, col_in_img;
  logic [DATA_WIDTH-1:0] in_pix;
  logic [K-1:0][DATA_WIDTH-1:0] col_vec;
  logic [K-1:0] row_mask;
  logic [K-1:0][K-1:0][DATA_WIDTH-1:0] win_next;

  // Beat classification on the (H+P) x (W+P) grid.
  assign col_in_img = col < CW'(w_q);
  assign consume    = col_in_img && (row < CW'(h_q));
  assign last_col   = col == CW'(w_q) + CW'(P) - CW'(1);
  assign last_row   = row == CW'(h_q) + CW'(P) - CW'(1);
  assign in_pix     = consume ? s_data : '0;
  assign total      = NW'(h_q) * NW'(w_q);

  if (P == 0) begin : g_emit_all
    assign emit = 1'b1;
  end else begin : g_emit_gate
    assign emit = (row >= CW'(P)) && (col >= CW'(P));
  end

  assign out_hold = m_valid && !m_ready;
  assign stall    = (emit && out_hold) || (consume && !s_valid);
  assign adv      = (state == ST_RUN) && !grid_end && !stall;
  assign accept   = m_valid && m_ready;
  assign s_ready  = (state == ST_RUN) && !grid_end && consume && !(emit && out_hold);
  assign busy     = state == ST_RUN;
  assign done     = state == ST_DONE;

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      ST_IDLE: if (start) state_n = (img_width == '0 || img_height == '0) ? ST_DONE : ST_RUN;
      ST_RUN:  if (accept && win_cnt == total - NW'(1)) state_n = ST_DONE;
      ST_DONE: state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      w_q      <= '0;
      h_q      <= '0;
      row      <= '0;
      col      <= '0;
      grid_end <= 1'b0;
      win_cnt  <= '0;
      m_valid  <= 1'b0;
      m_window <= '0;
    end else begin
      if (state == ST_IDLE && start) begin
        w_q      <= img_width;
        h_q      <= img_height;
        row      <= '0;
        col      <= '0;
        grid_end <= 1'b0;
        win_cnt  <= '0;
      end
      if (adv) begin
        if (last_col) begin
          col <= '0;
          if (last_row) grid_end <= 1'b1;
          else          row <= row + CW'(1);
        end else begin
          col <= col + CW'(1);
        end
      end
      if (accept) win_cnt <= win_cnt + NW'(1);
      if (adv && emit) begin
        m_valid  <= 1'b1;
        m_window <= win_next;
      end else if (m_ready) begin
        m_valid  <= 1'b0;
      end
    end
  end

  // Bottom window row is the live input column.
  assign col_vec[K-1]  = s_data;
  assign row_mask[K-1] = consume;

  if (K > 1) begin : g_lb
    localparam int LBW = $clog2(MAX_W);
    logic [K-2:0][DATA_WIDTH-1:0] lb_rd, lb_wr;
    logic [CW-1:0] nxt_col;
    logic lb_we, lb_re;

    // Read the next beat's column now so the BRAM latency is hidden.
    assign nxt_col = last_col ? '0 : col + CW'(1);
    assign lb_we   = adv && col_in_img;
    assign lb_re   = adv && (nxt_col < CW'(w_q));

    for (genvar k = 0; k < K - 1; k++) begin : g_row
      // Line buffer k holds image row (row-1-k); rows outside the image read as zero.
      assign col_vec[K-2-k]  = lb_rd[k];
      assign row_mask[K-2-k] = col_in_img && (row >= CW'(k + 1))
                               && ((row - CW'(k + 1)) < CW'(h_q));
      if (k == 0) begin : g_first
        assign lb_wr[k] = in_pix;
      end else begin : g_casc
        assign lb_wr[k] = row_mask[K-1-k] ? lb_rd[k-1] : '0;
      end

      sdp_bram #(.DW(DATA_WIDTH), .DEPTH(MAX_W)) u_lb (
        .clk     (clk),
        .wr_en   (lb_we),
        .wr_addr (col[LBW-1:0]),
        .wr_data (lb_wr[k]),
        .rd_en   (lb_re),
        .rd_addr (nxt_col[LBW-1:0]),
        .rd_data (lb_rd[k])
      );
    end
  end

  window_shift_reg_kxk #(.DW(DATA_WIDTH), .K(K)) u_win (
    .clk      (clk),
    .reset    (reset),
    .en       (adv),
    .clr      (col == '0),
    .mask     (row_mask),
    .col      (col_vec),
    .win_next (win_next)
  );
endmodule

// File: tb/tb_sliding_window_gen.sv
// Drives K=1/3/5 instances with directed and random frames against a zero-padded window model.
module tb_sliding_window_gen;
  localparam int DW = 16, MW = 128, AW = $clog2(MW) + 1, XW = 400;

  logic clk = 1'b0, reset = 1'b1;
  logic start1 = 1'b0, start3 = 1'b0, start5 = 1'b0, s_valid = 1'b0, m_ready = 1'b1;
  logic [AW-1:0] img_width = '0, img_height = '0;
  logic [DW-1:0] s_data = '0;
  logic s_ready1, s_ready3, s_ready5, m_valid1, m_valid3, m_valid5;
  logic busy1, busy3, busy5, done1, done3, done5;
  logic [DW-1:0] win1;
  logic [9*DW-1:0] win3;
  logic [25*DW-1:0] win5;
  int cur_k = 3;
  logic t_sready, t_mvalid, t_busy, t_done;
  logic [XW-1:0] t_win;
  int n_chk = 0, n_pass = 0;
  int pix[$];
  logic [XW-1:0] exp_q[$];

  always #5 clk = ~clk;

  sliding_window_gen #(.DATA_WIDTH(DW), .K(1), .MAX_W(MW)) u_k1 (
    .clk(clk), .reset(reset), .start(start1), .img_width(img_width), .img_height(img_height),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready1), .m_window(win1),
    .m_valid(m_valid1), .m_ready(m_ready), .busy(busy1), .done(done1));
  sliding_window_gen #(.DATA_WIDTH(DW), .K(3), .MAX_W(MW)) u_k3 (
    .clk(clk), .reset(reset), .start(start3), .img_width(img_width), .img_height(img_height),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready3), .m_window(win3),
    .m_valid(m_valid3), .m_ready(m_ready), .busy(busy3), .done(done3));
  sliding_window_gen #(.DATA_WIDTH(DW), .K(5), .MAX_W(MW)) u_k5 (
    .clk(clk), .reset(reset), .start(start5), .img_width(img_width), .img_height(img_height),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready5), .m_window(win5),
    .m_valid(m_valid5), .m_ready(m_ready), .busy(busy5), .done(done5));

  always_comb begin
    t_sready = s_ready3; t_mvalid = m_valid3; t_busy = busy3; t_done = done3; t_win = XW'(win3);
    if (cur_k == 1) begin
      t_sready = s_ready1; t_mvalid = m_valid1; t_busy = busy1; t_done = done1; t_win = XW'(win1);
    end else if (cur_k == 5) begin
      t_sready = s_ready5; t_mvalid = m_valid5; t_busy = busy5; t_done = done5; t_win = XW'(win5);
    end
  end

  task automatic chk(input string tag, input logic [XW-1:0] got, input logic [XW-1:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Window centred at (y,x) with same-size zero padding, element (r,c) at slot r*k+c.
  function automatic logic [XW-1:0] exp_win(input int k, input int w, input int h, input int y, input int x);
    logic [XW-1:0] v = '0;
    int p = (k - 1) / 2;
    for (int r = 0; r < k; r++)
      for (int c = 0; c < k; c++) begin
        int yy, xx;
        yy = y + r - p; xx = x + c - p;
        if (yy >= 0 && yy < h && xx >= 0 && xx < w) v[(r*k+c)*DW +: DW] = DW'(pix[yy*w+xx]);
      end
    return v;
  endfunction

  function automatic logic [XW-1:0] mk3(input int e[9]);
    logic [XW-1:0] v = '0;
    for (int i = 0; i < 9; i++) v[i*DW +: DW] = DW'(e[i]);
    return v;
  endfunction

  task automatic set_start(input int k, input logic v);
    start1 = (k == 1) && v; start3 = (k == 3) && v; start5 = (k == 5) && v;
  endtask

  task automatic run_frame(input int k, input int w, input int h, input int vmode, input int rmode,
                           input int abort_at, input bit restart, input int base,
                           output logic [XW-1:0] first_win, output logic [XW-1:0] last_win,
                           output int cyc, output int first_cyc);
    int p, idx, nacc, limit, beats;
    bit hold, fin, any_s, any_m;
    logic [XW-1:0] held, e;
    p = (k - 1) / 2; idx = 0; nacc = 0; hold = 0; fin = 0; any_s = 0; any_m = 0; held = '0;
    beats = (h + p) * (w + p);
    limit = (vmode == 0 && rmode == 0) ? beats + 10 : 8 * beats + 50;
    pix.delete(); exp_q.delete();
    for (int n = 0; n < h * w; n++) pix.push_back(base != 0 ? base + n : int'($urandom_range(0, 65535)));
    for (int y = 0; y < h; y++) for (int x = 0; x < w; x++) exp_q.push_back(exp_win(k, w, h, y, x));
    cur_k = k; img_width = AW'(w); img_height = AW'(h);
    first_win = '0; last_win = '0; cyc = 0; first_cyc = 0;
    @(negedge clk); set_start(k, 1'b1);
    @(negedge clk); set_start(k, 1'b0);
    while (!fin && cyc < limit) begin
      cyc++;
      set_start(k, restart && cyc == 5);
      if (restart && cyc >= 5) img_width = AW'(w + 3);
      s_valid = (vmode == 0) ? 1'b1 : (vmode == 1) ? (cyc % 2 == 1) : 1'($urandom_range(0, 1));
      s_data  = idx < pix.size() ? DW'(pix[idx]) : DW'($urandom);
      m_ready = (rmode == 0) ? 1'b1 : (rmode == 1) ? !(cyc >= 9 && cyc < 14) : ($urandom_range(0, 3) != 0);
      #1;
      if (cyc == 1 && h > 0) chk("busy", XW'(t_busy), XW'(1));
      if (hold) chk("hold", t_win, held);
      any_s |= t_sready; any_m |= t_mvalid;
      if (t_mvalid && m_ready) begin
        if (exp_q.size() == 0) chk("extra_win", XW'(1), XW'(0));
        else begin
          e = exp_q.pop_front();
          chk("window", t_win, e);
          if (nacc == 0) begin first_win = t_win; first_cyc = cyc; end
          last_win = t_win; nacc++;
        end
      end
      hold = t_mvalid && !m_ready; held = t_win;
      if (s_valid && t_sready) idx++;
      chk("lag", XW'(idx - nacc <= p * w + p + 1), XW'(1));
      if (t_done) fin = 1;
      if (abort_at > 0 && nacc == abort_at) begin
        reset = 1'b1; s_valid = 1'b0;
        @(negedge clk); #1;
        chk("abort_state", XW'({t_sready, t_mvalid, t_busy, t_done}), XW'(0));
        chk("abort_win", t_win, XW'(0));
        reset = 1'b0;
        return;
      end
      if (!fin) @(negedge clk);
    end
    s_valid = 1'b0; set_start(k, 1'b0);
    if (!fin) chk("timeout", XW'(0), XW'(1));
    chk("n_windows", XW'(nacc), XW'(h * w));
    chk("n_pixels", XW'(idx), XW'(h * w));
    if (h == 0 || w == 0) begin
      chk("empty_hs", XW'({any_s, any_m}), XW'(0));
      chk("empty_done_lat", XW'(cyc), XW'(1));
    end else if (vmode == 0 && rmode == 0) begin
      chk("cycles", XW'(cyc <= beats + 4), XW'(1));
      chk("first_lat", XW'(first_cyc), XW'(p * (w + p) + p + 2));
    end
    @(negedge clk); #1;
    chk("done_pulse", XW'(t_done), XW'(0));
  endtask

  initial begin
    logic [XW-1:0] fw, lw, m;
    int cyc, fc, ks[3];
    ks = '{1, 3, 5};
    repeat (3) @(negedge clk);
    #1;
    chk("rst_sready", XW'({s_ready1, s_ready3, s_ready5}), XW'(0));
    chk("rst_mvalid", XW'({m_valid1, m_valid3, m_valid5}), XW'(0));
    chk("rst_busy_done", XW'({busy1, busy3, busy5, done1, done3, done5}), XW'(0));
    chk("rst_win", XW'(win1) | XW'(win3) | win5, XW'(0));
    reset = 1'b0;

    run_frame(3, 4, 3, 0, 0, 0, 0, 1, fw, lw, cyc, fc);
    chk("first_rows", fw, mk3('{0, 0, 0, 0, 1, 2, 0, 5, 6}));
    chk("last_rows", lw, mk3('{7, 8, 0, 11, 12, 0, 0, 0, 0}));
    run_frame(3, 4, 3, 0, 1, 0, 0, 1, fw, lw, cyc, fc);
    run_frame(3, 4, 3, 1, 0, 0, 1, 1, fw, lw, cyc, fc);
    chk("toggle_first", fw, mk3('{0, 0, 0, 0, 1, 2, 0, 5, 6}));
    run_frame(3, 4, 3, 0, 0, 6, 0, 1, fw, lw, cyc, fc);
    run_frame(3, 4, 3, 0, 0, 0, 0, 101, fw, lw, cyc, fc);
    chk("post_abort_first", fw, mk3('{0, 0, 0, 0, 101, 102, 0, 105, 106}));

    run_frame(5, 128, 2, 0, 0, 0, 0, 0, fw, lw, cyc, fc);
    m = '0;
    for (int r = 0; r < 5; r++) begin m[(r*5+3)*DW +: DW] = '1; m[(r*5+4)*DW +: DW] = '1; end
    chk("col127_pad", lw & m, XW'(0));
    chk("k5_cycles", XW'(cyc <= 134 * 4 + 4), XW'(1));

    run_frame(3, 4, 0, 0, 0, 0, 0, 1, fw, lw, cyc, fc);
    run_frame(1, 5, 2, 0, 0, 0, 0, 200, fw, lw, cyc, fc);
    chk("k1_first", fw, XW'(200));

    for (int n = 0; n < 8; n++)
      run_frame(ks[$urandom_range(0, 2)], $urandom_range(1, 9), $urandom_range(1, 6), 2, 2, 0, 0, 0,
                fw, lw, cyc, fc);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
